// File: rtl/sample_stream_fifo_if.sv
`timescale 1ns/1ps
// SDRAM read-port bundle between the sample streamer (master) and the bridge (slave).
interface sample_stream_fifo_if;
    logic        tl_read;
    logic [31:0] tl_addr;
    logic        tl_rdv;
    logic [31:0] tl_rd;

    modport master (output tl_read, output tl_addr, input tl_rdv, input tl_rd);
    modport slave  (input tl_read, input tl_addr, output tl_rdv, output tl_rd);
endinterface

// File: rtl/sample_stream_fifo.sv
`timescale 1ns/1ps
// Prefetching song-word streamer: single-word SDRAM reads into a small FIFO,
// one word presented per rising edge of data_over, done pulse at end of song.
module sample_stream_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 25
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic [31:0]          base_addr,
    input  logic [CNT_W-1:0]     num_words,
    input  logic                 data_over,
    sample_stream_fifo_if.master tl,
    output logic [31:0]          sample,
    output logic [3:0]           notes,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           underrun_cnt
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [31:0]        rd_addr_q;
    logic [31:0]        tl_addr_q;
    logic               tl_read_q;
    logic [CNT_W-1:0]   num_q;
    logic [CNT_W-1:0]   fetched_q;
    logic [CNT_W-1:0]   played_q;

    logic [31:0]        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [OCC_W-1:0]   count_q;

    logic               do_q;
    logic [31:0]        sample_q;
    logic               busy_q;
    logic               done_q;
    logic [7:0]         underrun_q;

    logic               start_ok;
    logic               can_issue;
    logic               pop_req;
    logic               pop;
    logic               underrun;
    logic               last_pop;
    logic               load;
    logic               issue;
    logic               push;

    assign start_ok  = start & ~busy_q & (state_q == S_IDLE);
    assign can_issue = (fetched_q < num_q) & (count_q < OCC_W'(DEPTH)) & ~done_q;
    assign pop_req   = data_over & ~do_q & busy_q & ~done_q;
    assign pop       = pop_req & (count_q != '0);
    assign underrun  = pop_req & (count_q == '0);
    assign last_pop  = pop & ((played_q + CNT_W'(1)) == num_q);

    // Fetch FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch FSM next state; the first read goes out straight from IDLE so
    // tl_read is already up the cycle after start.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok && (num_words != '0)) begin
                    state_d = S_WAIT;
                end
            end
            S_REQ: begin
                if (done_q) begin
                    state_d = S_IDLE;
                end else if (can_issue) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tl.tl_rdv) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Fetch FSM strobes: song load, read issue, FIFO push on returned data.
    always_comb begin
        load  = 1'b0;
        issue = 1'b0;
        push  = 1'b0;
        unique case (state_q)
            S_IDLE:  load  = start_ok;
            S_REQ:   issue = can_issue;
            S_WAIT:  push  = tl.tl_rdv;
            default: ;
        endcase
    end

    // Read port registers, read address and fetched-word counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            tl_read_q <= 1'b0;
            tl_addr_q <= '0;
            rd_addr_q <= '0;
            num_q     <= '0;
            fetched_q <= '0;
        end else begin
            tl_read_q <= (state_d == S_WAIT);
            if (load) begin
                rd_addr_q <= base_addr;
                tl_addr_q <= base_addr;
                num_q     <= num_words;
                fetched_q <= '0;
            end
            if (issue) begin
                tl_addr_q <= rd_addr_q;
            end
            if (push) begin
                rd_addr_q <= rd_addr_q + 32'd4;
                fetched_q <= fetched_q + CNT_W'(1);
            end
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr_q] <= tl.tl_rd;
        end
    end

    // FIFO pointers and occupancy; pop on an empty FIFO is an underrun, not a pop.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + OCC_W'(1);
                2'b01:   count_q <= count_q - OCC_W'(1);
                default: ;
            endcase
        end
    end

    // Play path: sample request edge detect, presented word, song progress.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            do_q       <= 1'b0;
            sample_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            played_q   <= '0;
            underrun_q <= '0;
        end else begin
            do_q   <= data_over;
            done_q <= last_pop | (start_ok & (num_words == '0));
            if (start_ok) begin
                busy_q   <= 1'b1;
                played_q <= '0;
            end else if (done_q) begin
                busy_q <= 1'b0;
            end
            if (done_q) begin
                sample_q <= '0;
            end
            if (pop) begin
                sample_q <= mem[rd_ptr_q];
                played_q <= played_q + CNT_W'(1);
            end
            if (underrun) begin
                sample_q <= '0;
                if (underrun_q != 8'hFF) begin
                    underrun_q <= underrun_q + 8'd1;
                end
            end
        end
    end

    assign tl.tl_read   = tl_read_q;
    assign tl.tl_addr   = tl_addr_q;
    assign sample       = sample_q;
    assign notes        = {sample_q[20], sample_q[16], sample_q[28], sample_q[24]};
    assign busy         = busy_q;
    assign done         = done_q;
    assign underrun_cnt = underrun_q;
endmodule
